// File: rtl/vx_commit_arb.sv
// Merges per-unit commit streams into one writeback stream: round-robin with packet lock,
// 2-entry output FIFO and retired-instruction counter. Define COMMIT_ARB_PERF_EN for stall counters.
module vx_commit_arb #(
  parameter int unsigned NUM_UNITS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NW_BITS     = 2,
  parameter int unsigned PC_BITS     = 32,
  parameter int unsigned RD_BITS     = 6,
  localparam int unsigned UW         = $clog2(NUM_UNITS)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_UNITS-1:0]                in_valid,
  output logic [NUM_UNITS-1:0]                in_ready,
  input  logic [NUM_UNITS*NW_BITS-1:0]        in_wid,
  input  logic [NUM_UNITS*NUM_THREADS-1:0]    in_tmask,
  input  logic [NUM_UNITS*PC_BITS-1:0]        in_pc,
  input  logic [NUM_UNITS-1:0]                in_wb,
  input  logic [NUM_UNITS*RD_BITS-1:0]        in_rd,
  input  logic [NUM_UNITS*NUM_THREADS*XLEN-1:0] in_data,
  input  logic [NUM_UNITS-1:0]                in_eop,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NW_BITS-1:0]                  out_wid,
  output logic [NUM_THREADS-1:0]              out_tmask,
  output logic [PC_BITS-1:0]                  out_pc,
  output logic                                out_wb,
  output logic [RD_BITS-1:0]                  out_rd,
  output logic [NUM_THREADS*XLEN-1:0]         out_data,
  output logic                                out_eop,
  output logic [UW-1:0]                       out_unit,
  output logic [63:0]                         instret
`ifdef COMMIT_ARB_PERF_EN
  ,
  output logic [NUM_UNITS*32-1:0]             perf_stall_cycles
`endif
);

  localparam int unsigned DW = NUM_THREADS * XLEN;

  typedef struct packed {
    logic [UW-1:0]          unit;
    logic [NW_BITS-1:0]     wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_BITS-1:0]     pc;
    logic                   wb;
    logic [RD_BITS-1:0]     rd;
    logic [DW-1:0]          data;
    logic                   eop;
  } beat_t;

  logic [UW-1:0]        ptr_q, ptr_d;
  logic                 lock_q, lock_d;
  logic [UW-1:0]        lock_unit_q, lock_unit_d;
  logic [NUM_UNITS-1:0] grant;
  logic [UW-1:0]        grant_idx;
  logic                 grant_any;
  logic [UW-1:0]        cand;

  beat_t                mem_q [2];
  beat_t                mem_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [63:0]          instret_q, instret_d;

  beat_t                push_beat;
  beat_t                head;
  logic                 full;
  logic                 push;
  logic                 pop;

  // A locked packet owns the grant; otherwise first valid unit at or after the pointer wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (lock_q) begin
      grant_idx = lock_unit_q;
      grant_any = in_valid[lock_unit_q];
    end else begin
      for (int unsigned j = 0; j < NUM_UNITS; j++) begin
        cand = UW'((32'(ptr_q) + j) % NUM_UNITS);
        if (!grant_any && in_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    grant[grant_idx] = grant_any;
  end

  assign full      = (count_q == 2'd2);
  assign in_ready  = grant & {NUM_UNITS{~full & reset_n}};
  assign push      = grant_any & ~full & reset_n;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;

  always_comb begin
    push_beat      = '0;
    push_beat.unit = grant_idx;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (grant_idx == UW'(i)) begin
        push_beat.wid   = in_wid[i*NW_BITS +: NW_BITS];
        push_beat.tmask = in_tmask[i*NUM_THREADS +: NUM_THREADS];
        push_beat.pc    = in_pc[i*PC_BITS +: PC_BITS];
        push_beat.wb    = in_wb[i];
        push_beat.rd    = in_rd[i*RD_BITS +: RD_BITS];
        push_beat.data  = in_data[i*DW +: DW];
        push_beat.eop   = in_eop[i];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    lock_unit_d = lock_unit_q;
    if (push) begin
      ptr_d       = (grant_idx == UW'(NUM_UNITS - 1)) ? '0 : grant_idx + UW'(1);
      lock_d      = ~push_beat.eop;
      lock_unit_d = grant_idx;
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_beat;
    end
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    count_d   = count_q + 2'(push) - 2'(pop);
    instret_d = instret_q + 64'(pop & head.eop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_unit_q <= '0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      instret_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_unit_q <= lock_unit_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      instret_q   <= instret_d;
    end
  end

  assign out_wid   = head.wid;
  assign out_tmask = head.tmask;
  assign out_pc    = head.pc;
  assign out_wb    = head.wb;
  assign out_rd    = head.rd;
  assign out_data  = head.data;
  assign out_eop   = head.eop;
  assign out_unit  = head.unit;
  assign instret   = instret_q;

`ifdef COMMIT_ARB_PERF_EN
  logic [NUM_UNITS*32-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (in_valid[i] && !in_ready[i] && (perf_q[i*32 +: 32] != 32'hFFFF_FFFF)) begin
        perf_d[i*32 +: 32] = perf_q[i*32 +: 32] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cycles = perf_q;
`endif

  // Producers must hold valid and payload while stalled.
  for (genvar i = 0; i < int'(NUM_UNITS); i++) begin : g_hs_chk
    assert property (@(posedge clk) disable iff (!reset_n)
      (in_valid[i] && !in_ready[i]) |=> (in_valid[i]
        && $stable(in_wid[i*NW_BITS +: NW_BITS])
        && $stable(in_tmask[i*NUM_THREADS +: NUM_THREADS])
        && $stable(in_pc[i*PC_BITS +: PC_BITS])
        && $stable(in_wb[i])
        && $stable(in_rd[i*RD_BITS +: RD_BITS])
        && $stable(in_data[i*DW +: DW])
        && $stable(in_eop[i])));
  end

  assert property (@(posedge clk) disable iff (!reset_n) $onehot0(in_ready));

endmodule

// File: tb/tb_vx_commit_arb.sv
// Bench for vx_commit_arb: per-unit producer queues, a spec-level arbitration/FIFO model
// compared every cycle, and directed scenarios pinned by literal expectations.
module tb_vx_commit_arb;
  localparam int NU = 4, NT = 4, XL = 32, NWB = 2, PCB = 32, RDB = 6;

  typedef struct packed {
    logic [1:0]   unit;
    logic [1:0]   wid;
    logic [3:0]   tmask;
    logic [31:0]  pc;
    logic         wb;
    logic [5:0]   rd;
    logic [127:0] data;
    logic         eop;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [NU-1:0]       in_valid, in_ready, in_wb, in_eop;
  logic [NU*NWB-1:0]   in_wid;
  logic [NU*NT-1:0]    in_tmask;
  logic [NU*PCB-1:0]   in_pc;
  logic [NU*RDB-1:0]   in_rd;
  logic [NU*NT*XL-1:0] in_data;
  logic                out_valid, out_ready, out_wb, out_eop;
  logic [1:0]          out_wid, out_unit;
  logic [3:0]          out_tmask;
  logic [31:0]         out_pc;
  logic [5:0]          out_rd;
  logic [127:0]        out_data;
  logic [63:0]         instret;
`ifdef COMMIT_ARB_PERF_EN
  logic [NU*32-1:0]    perf_stall_cycles;
`endif

  vx_commit_arb #(
    .NUM_UNITS(NU), .NUM_THREADS(NT), .XLEN(XL), .NW_BITS(NWB), .PC_BITS(PCB), .RD_BITS(RDB)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_tmask(in_tmask),
    .in_pc(in_pc), .in_wb(in_wb), .in_rd(in_rd), .in_data(in_data), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_tmask(out_tmask),
    .out_pc(out_pc), .out_wb(out_wb), .out_rd(out_rd), .out_data(out_data), .out_eop(out_eop),
    .out_unit(out_unit), .instret(instret)
`ifdef COMMIT_ARB_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_chk, n_fail;
  beat_t prod [NU][$];
  beat_t exp_q [$];
  int ptr_m, lock_u_m;
  bit lock_m;
  logic [63:0] instret_m;
  int unsigned perf_m [NU];
  int fire_log [$];
  int acc_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input int u, input int seq, input logic eop, input logic wb);
    beat_t b;
    b.unit  = 2'(u);
    b.wid   = 2'(u + seq);
    b.tmask = 4'hF ^ 4'(u);
    b.pc    = 32'h1000_0000 + 32'(u) * 32'h100 + 32'(seq) * 32'd4;
    b.wb    = wb;
    b.rd    = 6'(u * 8 + seq);
    b.data  = {b.pc, ~b.pc, b.pc ^ 32'h5a5a_5a5a, b.pc + 32'd7};
    b.eop   = eop;
    return b;
  endfunction

  task automatic drive_inputs();
    for (int u = 0; u < NU; u++) begin
      beat_t b;
      b = (prod[u].size() > 0) ? prod[u][0] : '0;
      in_valid[u]              = (prod[u].size() > 0);
      in_wid[u*NWB +: NWB]     = b.wid;
      in_tmask[u*NT +: NT]     = b.tmask;
      in_pc[u*PCB +: PCB]      = b.pc;
      in_wb[u]                 = b.wb;
      in_rd[u*RDB +: RDB]      = b.rd;
      in_data[u*NT*XL +: NT*XL] = b.data;
      in_eop[u]                = b.eop;
    end
  endtask

  task automatic clear_model();
    ptr_m = 0; lock_m = 1'b0; lock_u_m = 0; instret_m = '0;
    exp_q.delete();
    for (int u = 0; u < NU; u++) begin
      prod[u].delete();
      perf_m[u] = 0;
    end
  endtask

  function automatic bit busy();
    bit r;
    r = (exp_q.size() > 0);
    for (int u = 0; u < NU; u++) if (prod[u].size() > 0) r = 1'b1;
    return r;
  endfunction

  // One clock: compare at the falling edge, advance the model after the rising edge.
  task automatic tick();
    int cand, acc;
    bit full, pop;
    logic [NU-1:0] exp_rdy, stall;
    beat_t b;
    @(negedge clk);
    exp_rdy = '0; stall = '0; acc = -1; pop = 1'b0;
    if (reset_n) begin
      full = (exp_q.size() == 2);
      cand = -1;
      if (lock_m) begin
        if (prod[lock_u_m].size() > 0) cand = lock_u_m;
      end else begin
        for (int j = 0; j < NU; j++) begin
          int u;
          u = (ptr_m + j) % NU;
          if (cand < 0 && prod[u].size() > 0) cand = u;
        end
      end
      if (cand >= 0 && !full) begin
        exp_rdy = NU'(1) << cand;
        acc = cand;
      end
      for (int u = 0; u < NU; u++) stall[u] = (prod[u].size() > 0) && !exp_rdy[u];
      pop = (exp_q.size() > 0) && out_ready;
      chk("in_ready", 128'(in_ready), 128'(exp_rdy));
      chk("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
      chk("instret", 128'(instret), 128'(instret_m));
      if (exp_q.size() > 0) begin
        chk("out_unit", 128'(out_unit), 128'(exp_q[0].unit));
        chk("out_wid", 128'(out_wid), 128'(exp_q[0].wid));
        chk("out_tmask", 128'(out_tmask), 128'(exp_q[0].tmask));
        chk("out_pc", 128'(out_pc), 128'(exp_q[0].pc));
        chk("out_wb", 128'(out_wb), 128'(exp_q[0].wb));
        chk("out_rd", 128'(out_rd), 128'(exp_q[0].rd));
        chk("out_data", out_data, exp_q[0].data);
        chk("out_eop", 128'(out_eop), 128'(exp_q[0].eop));
      end
`ifdef COMMIT_ARB_PERF_EN
      for (int u = 0; u < NU; u++)
        chk("perf", 128'(perf_stall_cycles[u*32 +: 32]), 128'(perf_m[u]));
`endif
      if (out_valid && out_ready) fire_log.push_back(int'(out_unit));
      if ((in_valid & in_ready) != '0) acc_cnt++;
    end
    @(posedge clk);
    #1;
    if (reset_n) begin
      if (pop) begin
        instret_m += 64'(exp_q[0].eop);
        void'(exp_q.pop_front());
      end
      if (acc >= 0) begin
        b = prod[acc].pop_front();
        exp_q.push_back(b);
        ptr_m    = (acc + 1) % NU;
        lock_m   = !b.eop;
        lock_u_m = acc;
      end
      for (int u = 0; u < NU; u++)
        if (stall[u] && perf_m[u] != 32'hFFFF_FFFF) perf_m[u]++;
    end
    drive_inputs();
  endtask

  task automatic drain(input int lim, output int cyc);
    cyc = 0;
    while (busy() && cyc < lim) begin
      tick();
      cyc++;
    end
    chk("drain_done", 128'(busy()), 128'(0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_instret", 128'(instret), 128'(0));
    chk("rst_out_pc", 128'(out_pc), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_out_unit", 128'(out_unit), 128'(0));
    clear_model();
    drive_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    beat_t b;
    int cyc;
    n_chk = 0; n_fail = 0; acc_cnt = 0;
    out_ready = 1'b0;
    in_valid = '0; in_wid = '0; in_tmask = '0; in_pc = '0; in_wb = '0;
    in_rd = '0; in_data = '0; in_eop = '0;
    clear_model();
    #1;
    do_reset();

    // Single beat, latency 1.
    out_ready = 1'b1;
    b = mk(1, 0, 1'b1, 1'b1);
    b.wid = 2'd2;
    b.rd  = 6'd5;
    prod[1].push_back(b);
    fire_log.delete();
    drive_inputs();
    tick();
    chk("t1_valid", 128'(out_valid), 128'(1));
    chk("t1_unit", 128'(out_unit), 128'(1));
    chk("t1_wid", 128'(out_wid), 128'(2));
    chk("t1_rd", 128'(out_rd), 128'(5));
    chk("t1_instret0", 128'(instret), 128'(0));
    tick();
    chk("t1_instret1", 128'(instret), 128'(1));
    chk("t1_fires", 128'(fire_log.size()), 128'(1));

    // All units streaming single-beat packets; unit 3 beats have wb=0.
    do_reset();
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++)
      for (int u = 0; u < NU; u++) prod[u].push_back(mk(u, s, 1'b1, u != 3));
    fire_log.delete();
    drive_inputs();
    drain(60, cyc);
    chk("t2_cycles", 128'(cyc), 128'(17));
    chk("t2_instret", 128'(instret), 128'(16));
    chk("t2_nfire", 128'(fire_log.size()), 128'(16));
    for (int i = 0; i < 16 && i < fire_log.size(); i++)
      chk("t2_order", 128'(fire_log[i]), 128'(i % 4));

    // Packet lock: unit 2 three-beat packet while units 0 and 3 wait.
    do_reset();
    out_ready = 1'b1;
    prod[1].push_back(mk(1, 0, 1'b1, 1'b1));
    drive_inputs();
    drain(20, cyc);
    fire_log.delete();
    prod[2].push_back(mk(2, 0, 1'b0, 1'b1));
    prod[2].push_back(mk(2, 1, 1'b0, 1'b1));
    prod[2].push_back(mk(2, 2, 1'b1, 1'b1));
    prod[0].push_back(mk(0, 0, 1'b1, 1'b1));
    prod[3].push_back(mk(3, 0, 1'b1, 1'b0));
    drive_inputs();
    drain(40, cyc);
    chk("t3_nfire", 128'(fire_log.size()), 128'(5));
    if (fire_log.size() == 5) begin
      chk("t3_o0", 128'(fire_log[0]), 128'(2));
      chk("t3_o1", 128'(fire_log[1]), 128'(2));
      chk("t3_o2", 128'(fire_log[2]), 128'(2));
      chk("t3_o3", 128'(fire_log[3]), 128'(3));
      chk("t3_o4", 128'(fire_log[4]), 128'(0));
    end
    chk("t3_instret", 128'(instret), 128'(4));

    // Backpressure: only two beats fit while out_ready is low.
    do_reset();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++)
      for (int u = 0; u < NU; u++) prod[u].push_back(mk(u, s, 1'b1, 1'b1));
    acc_cnt = 0;
    drive_inputs();
    for (int i = 0; i < 5; i++) tick();
    chk("t4_accepted", 128'(acc_cnt), 128'(2));
    chk("t4_ready", 128'(in_ready), 128'(0));
    chk("t4_valid", 128'(out_valid), 128'(1));
    chk("t4_unit", 128'(out_unit), 128'(0));
    chk("t4_pc", 128'(out_pc), 128'(32'h1000_0000));
    out_ready = 1'b1;
    fire_log.delete();
    drain(60, cyc);
    chk("t4_nfire", 128'(fire_log.size()), 128'(12));
    for (int i = 0; i < 12 && i < fire_log.size(); i++)
      chk("t4_order", 128'(fire_log[i]), 128'(i % 4));
    chk("t4_instret", 128'(instret), 128'(12));

    // Reset mid-packet with a full buffer; lock on unit 2 must not survive.
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) prod[2].push_back(mk(2, s, 1'b0, 1'b1));
    drive_inputs();
    for (int i = 0; i < 4; i++) tick();
    chk("t5_full_ready", 128'(in_ready), 128'(0));
    chk("t5_full_valid", 128'(out_valid), 128'(1));
    do_reset();
    out_ready = 1'b1;
    prod[0].push_back(mk(0, 0, 1'b1, 1'b1));
    prod[2].push_back(mk(2, 9, 1'b1, 1'b1));
    fire_log.delete();
    drive_inputs();
    drain(20, cyc);
    chk("t5_nfire", 128'(fire_log.size()), 128'(2));
    if (fire_log.size() == 2) begin
      chk("t5_first", 128'(fire_log[0]), 128'(0));
      chk("t5_second", 128'(fire_log[1]), 128'(2));
    end

`ifdef COMMIT_ARB_PERF_EN
    // Unit 1 waits behind a seven-beat locked packet from unit 0.
    do_reset();
    out_ready = 1'b1;
    for (int s = 0; s < 7; s++) prod[0].push_back(mk(0, s, s == 6, 1'b1));
    prod[1].push_back(mk(1, 0, 1'b1, 1'b1));
    drive_inputs();
    drain(40, cyc);
    chk("t6_perf1", 128'(perf_stall_cycles[63:32]), 128'(7));
    chk("t6_perf0", 128'(perf_stall_cycles[31:0]), 128'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_commit_arb.md
Name: vx_commit_arb

Overview:
- Downstream neighbour of the execute stage: merges the per-unit commit streams (ALU, LSU, FPU, SFU, ...) of one issue slot into a single writeback stream for the register file and scoreboard release.
- Fair round-robin arbitration, packet locking for multi-beat results, and a registered 2-entry output buffer that breaks the ready path.
- Maintains the retired-instruction counter consumed by the CSR unit.

Parameters:
- NUM_UNITS, 4, number of execute-unit commit inputs (>=2)
- NUM_THREADS, 4, lanes per warp
- XLEN, 32, data width per lane
- NW_BITS, 2, warp-id width
- PC_BITS, 32, PC width
- RD_BITS, 6, destination register index width (incl. FP bank bit)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  NUM_UNITS  per-unit commit valid
- in_ready  out  NUM_UNITS  per-unit commit accept
- in_wid  in  NUM_UNITS*NW_BITS  warp id per unit
- in_tmask  in  NUM_UNITS*NUM_THREADS  thread mask per unit
- in_pc  in  NUM_UNITS*PC_BITS  instruction PC per unit
- in_wb  in  NUM_UNITS  register write enable per unit
- in_rd  in  NUM_UNITS*RD_BITS  destination register per unit
- in_data  in  NUM_UNITS*NUM_THREADS*XLEN  result data per unit
- in_eop  in  NUM_UNITS  last beat of instruction per unit
- out_valid  out  1  writeback valid
- out_ready  in  1  writeback accept
- out_wid, out_tmask, out_pc, out_wb, out_rd, out_data, out_eop  out  (single-unit widths)  selected beat
- out_unit  out  $clog2(NUM_UNITS)  source unit of out beat
- instret  out  64  retired instruction count

Behaviour:
- Reset (async assert, sync deassert via the reset_n edge): out_valid=0, buffer empty, all payload outputs 0, instret=0, RR pointer=0, lock=0, in_ready=0.
- Handshake: a beat transfers on valid&ready; valid must not drop, nor payload change, until accepted (producer rule; asserted in sim).
- Arbitration:
  - Round-robin among in_valid starting at pointer.
  - On an accepted beat from unit k: pointer <= (k+1) mod NUM_UNITS.
  - Pointer unchanged when nothing is accepted.
- Packet lock:
  - Accepted beat with eop=0 sets lock to unit k; only unit k is granted until its eop=1 beat is accepted, then lock clears.
  - Other units stall (in_ready=0) meanwhile.
- in_ready[i] = grant[i] & ~buf_full; at most one bit set; in_ready does not depend combinationally on out_ready.
- Output buffer:
  - 2-entry FIFO; accepted beat appears on out_* the next cycle (latency 1) when the buffer was empty.
  - Full FIFO deasserts all in_ready.
  - Simultaneous push and pop when full is not allowed (ready already low).
  - Simultaneous push and pop with 1 entry keeps count=1.
  - Order preserved.
- out_* driven from the FIFO head; stable while out_valid & ~out_ready.
- instret: +1 on each output fire with out_eop=1; wraps modulo 2^64.
- Beats with wb=0 pass through unchanged (scoreboard release still needed).
- Reset mid-packet: lock, FIFO and pointer cleared; partial packets are discarded.

Optional Feature:
- COMMIT_ARB_PERF_EN
- Defined: adds output perf_stall_cycles (NUM_UNITS*32); per-unit counter increments each cycle in_valid[i]&~in_ready[i]; saturates at 2^32-1; reset 0.
- Undefined: port and counters absent; no logic generated.

Test Plan:
- Single unit 1 valid eop=1, wid=2, rd=5, out_ready=1 -> out_valid next cycle with same payload; out_unit=1; instret 0->1.
- All 4 units valid continuously, each beat eop=1, out_ready=1 -> grant order 0,1,2,3,0,... one beat per cycle; instret +1 per cycle.
- Unit 2 sends 3 beats (eop 0,0,1) while unit 0 and unit 3 are valid -> the 3 unit-2 beats are consecutive on out; then grant goes to unit 3, then unit 0.
- out_ready=0 for 5 cycles with all units valid -> exactly 2 beats accepted, then in_ready=0; out payload stable; after release, order preserved.
- reset_n pulsed low mid-packet with the buffer holding 2 entries -> out_valid=0, instret=0, lock cleared immediately; after deassert, unit 0 wins first.
- COMMIT_ARB_PERF_EN: unit 1 held off 7 cycles behind a locked unit 0 -> perf_stall_cycles[1]=7.
